// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: ALU op codes, forwarding selects, load actions.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND   = 4'd0,
        ALU_OR    = 4'd1,
        ALU_NAND  = 4'd2,
        ALU_NOR   = 4'd3,
        ALU_ADDU  = 4'd4,
        ALU_SUBU  = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_EQUAL = 4'd7
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        LdHold,
        LdBubble,
        LdCapture
    } stage_ld_e;

    // A bubble executes AND on zero operands; its result is never written back.
    localparam alu_ctrl_e CTRL_BUBBLE = ALU_AND;

endpackage

// File: rtl/alu_fwd_mux.sv
// One operand's forwarding compare and select: EX/MEM beats MEM/WB, register 0 never forwarded.
module alu_fwd_mux
    import alu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_we,
    input  logic [AW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_res,
    input  logic          memwb_we,
    input  logic [AW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] data,
    output fwd_sel_e      sel
);

    always_comb begin
        sel = FWD_REG;
        if (exmem_we && (exmem_rd != '0) && (exmem_rd == addr)) begin
            sel = FWD_EXMEM;
        end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == addr)) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        data = reg_data;
        unique case (sel)
            FWD_EXMEM: data = exmem_res;
            FWD_MEMWB: data = memwb_data;
            default:   data = reg_data;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage feeding the ALU: operand registers, forwarding and load-use hazard detection.
// Define ALU_OPND_FWD_EN for forwarding; otherwise every RAW dependency stalls via hazard_o.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          stall_i,
    input  logic          in_valid_i,
    input  logic [AW-1:0] rs_addr_i,
    input  logic [AW-1:0] rt_addr_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [DW-1:0] rs_data_i,
    input  logic [DW-1:0] rt_data_i,
    input  logic [DW-1:0] imm_i,
    input  logic          alusrc_i,
    input  logic [CW-1:0] ctrl_i,
    input  logic          reg_write_i,
    input  logic          mem_read_i,
    input  logic          exmem_we_i,
    input  logic [AW-1:0] exmem_rd_i,
    input  logic [DW-1:0] exmem_res_i,
    input  logic          memwb_we_i,
    input  logic [AW-1:0] memwb_rd_i,
    input  logic [DW-1:0] memwb_data_i,
    output logic [DW-1:0] src1_o,
    output logic [DW-1:0] src2_o,
    output logic [CW-1:0] ctrl_o,
    output logic [DW-1:0] store_o,
    output logic [AW-1:0] rd_o,
    output logic          reg_write_o,
    output logic          mem_read_o,
    output logic          valid_o,
    output logic          hazard_o
);

    localparam logic [CW-1:0] CtrlBubble = CW'(CTRL_BUBBLE);

    logic          valid_q, valid_d;
    logic          reg_write_q, reg_write_d;
    logic          mem_read_q, mem_read_d;
    logic          alusrc_q, alusrc_d;
    logic [CW-1:0] ctrl_q, ctrl_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] rs_addr_q, rs_addr_d;
    logic [AW-1:0] rt_addr_q, rt_addr_d;
    logic [DW-1:0] rs_data_q, rs_data_d;
    logic [DW-1:0] rt_data_q, rt_data_d;
    logic [DW-1:0] imm_q, imm_d;

    logic [DW-1:0] rs_fwd, rt_fwd;
    logic          load_use;
    stage_ld_e     ld_act;

    function automatic logic src_dep(input logic we, input logic [AW-1:0] rd,
                                     input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                     input logic use_rt);
        return we && (rd != '0) && ((rd == rs) || (use_rt && (rd == rt)));
    endfunction

    assign load_use = in_valid_i &
                      src_dep(valid_q & mem_read_q, rd_q, rs_addr_i, rt_addr_i, !alusrc_i);

`ifdef ALU_OPND_FWD_EN
    fwd_sel_e rs_sel, rt_sel;
    logic     unused_sel;

    alu_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
        .addr       (rs_addr_q),
        .reg_data   (rs_data_q),
        .exmem_we   (exmem_we_i),
        .exmem_rd   (exmem_rd_i),
        .exmem_res  (exmem_res_i),
        .memwb_we   (memwb_we_i),
        .memwb_rd   (memwb_rd_i),
        .memwb_data (memwb_data_i),
        .data       (rs_fwd),
        .sel        (rs_sel)
    );

    alu_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
        .addr       (rt_addr_q),
        .reg_data   (rt_data_q),
        .exmem_we   (exmem_we_i),
        .exmem_rd   (exmem_rd_i),
        .exmem_res  (exmem_res_i),
        .memwb_we   (memwb_we_i),
        .memwb_rd   (memwb_rd_i),
        .memwb_data (memwb_data_i),
        .data       (rt_fwd),
        .sel        (rt_sel)
    );

    assign unused_sel = ^{rs_sel, rt_sel};
    assign hazard_o   = load_use;
`else
    logic unused_fwd;

    assign rs_fwd     = rs_data_q;
    assign rt_fwd     = rt_data_q;
    assign unused_fwd = ^{exmem_res_i, memwb_data_i, rs_addr_q, rt_addr_q};
    // Without bypass paths, any in-flight writer of a source must drain first.
    assign hazard_o   = load_use | (in_valid_i &
                        (src_dep(valid_q & reg_write_q, rd_q, rs_addr_i, rt_addr_i, !alusrc_i) |
                         src_dep(exmem_we_i, exmem_rd_i, rs_addr_i, rt_addr_i, !alusrc_i) |
                         src_dep(memwb_we_i, memwb_rd_i, rs_addr_i, rt_addr_i, !alusrc_i)));
`endif

    always_comb begin
        ld_act = LdCapture;
        if (flush_i) begin
            ld_act = LdBubble;
        end else if (stall_i) begin
            ld_act = LdHold;
        end else if (hazard_o) begin
            ld_act = LdBubble;
        end
    end

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        alusrc_d    = alusrc_q;
        ctrl_d      = ctrl_q;
        rd_d        = rd_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        imm_d       = imm_q;
        unique case (ld_act)
            LdBubble: begin
                valid_d     = 1'b0;
                reg_write_d = 1'b0;
                mem_read_d  = 1'b0;
                alusrc_d    = 1'b0;
                ctrl_d      = CtrlBubble;
                rd_d        = '0;
                rs_addr_d   = '0;
                rt_addr_d   = '0;
                rs_data_d   = '0;
                rt_data_d   = '0;
                imm_d       = '0;
            end
            LdCapture: begin
                valid_d     = in_valid_i;
                reg_write_d = reg_write_i & in_valid_i;
                mem_read_d  = mem_read_i & in_valid_i;
                alusrc_d    = alusrc_i;
                ctrl_d      = ctrl_i;
                rd_d        = rd_addr_i;
                rs_addr_d   = rs_addr_i;
                rt_addr_d   = rt_addr_i;
                rs_data_d   = rs_data_i;
                rt_data_d   = rt_data_i;
                imm_d       = imm_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            alusrc_q    <= 1'b0;
            ctrl_q      <= CtrlBubble;
            rd_q        <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            alusrc_q    <= alusrc_d;
            ctrl_q      <= ctrl_d;
            rd_q        <= rd_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            imm_q       <= imm_d;
        end
    end

    assign src1_o      = rs_fwd;
    assign src2_o      = alusrc_q ? imm_q : rt_fwd;
    assign store_o     = rt_fwd;
    assign ctrl_o      = ctrl_q;
    assign rd_o        = rd_q;
    assign reg_write_o = reg_write_q;
    assign mem_read_o  = mem_read_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage; expected stage contents are queued at each edge.
module tb_alu_operand_stage;

    typedef struct {
        logic        valid, rw, mr, alusrc;
        logic [3:0]  ctrl;
        logic [4:0]  rd, rs, rt;
        logic [31:0] rsd, rtd, imm;
    } stage_t;

    logic        clk = 1'b0;
    logic        rst, flush, stall, in_valid, alusrc, reg_write, mem_read;
    logic [4:0]  rs_addr, rt_addr, rd_addr, exmem_rd, memwb_rd;
    logic [31:0] rs_data, rt_data, imm, exmem_res, memwb_data;
    logic [3:0]  ctrl;
    logic        exmem_we, memwb_we;
    logic [31:0] src1, src2, store;
    logic [3:0]  ctrl_out;
    logic [4:0]  rd_out;
    logic        reg_write_out, mem_read_out, valid_out, hazard;

    int     n_tests = 0;
    int     n_fail  = 0;
    stage_t sb[$];
    stage_t cur;
    stage_t bubble;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .stall_i      (stall),
        .in_valid_i   (in_valid),
        .rs_addr_i    (rs_addr),
        .rt_addr_i    (rt_addr),
        .rd_addr_i    (rd_addr),
        .rs_data_i    (rs_data),
        .rt_data_i    (rt_data),
        .imm_i        (imm),
        .alusrc_i     (alusrc),
        .ctrl_i       (ctrl),
        .reg_write_i  (reg_write),
        .mem_read_i   (mem_read),
        .exmem_we_i   (exmem_we),
        .exmem_rd_i   (exmem_rd),
        .exmem_res_i  (exmem_res),
        .memwb_we_i   (memwb_we),
        .memwb_rd_i   (memwb_rd),
        .memwb_data_i (memwb_data),
        .src1_o       (src1),
        .src2_o       (src2),
        .ctrl_o       (ctrl_out),
        .store_o      (store),
        .rd_o         (rd_out),
        .reg_write_o  (reg_write_out),
        .mem_read_o   (mem_read_out),
        .valid_o      (valid_out),
        .hazard_o     (hazard)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic dep(input logic we, input logic [4:0] rd);
        return we && (rd != 5'd0) && ((rd == rs_addr) || (!alusrc && (rd == rt_addr)));
    endfunction

    function automatic logic exp_hazard(input stage_t s);
        logic h;
        h = in_valid && dep(s.valid && s.mr, s.rd);
`ifndef ALU_OPND_FWD_EN
        h = h || (in_valid && (dep(s.valid && s.rw, s.rd) || dep(exmem_we, exmem_rd) ||
                               dep(memwb_we, memwb_rd)));
`endif
        return h;
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
`ifdef ALU_OPND_FWD_EN
        if (exmem_we && exmem_rd != 5'd0 && exmem_rd == a) return exmem_res;
        if (memwb_we && memwb_rd != 5'd0 && memwb_rd == a) return memwb_data;
`endif
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        logic [31:0] rtv;
        rtv = fwd(cur.rt, cur.rtd);
        check({tag, ".valid"}, 32'(valid_out), 32'(cur.valid));
        check({tag, ".rw"}, 32'(reg_write_out), 32'(cur.rw));
        check({tag, ".mr"}, 32'(mem_read_out), 32'(cur.mr));
        check({tag, ".ctrl"}, 32'(ctrl_out), 32'(cur.ctrl));
        check({tag, ".rd"}, 32'(rd_out), 32'(cur.rd));
        check({tag, ".src1"}, src1, fwd(cur.rs, cur.rsd));
        check({tag, ".src2"}, src2, cur.alusrc ? cur.imm : rtv);
        check({tag, ".store"}, store, rtv);
    endtask

    // One clock: check hazard before the edge, queue the expected capture, compare after.
    task automatic step(input string tag);
        stage_t nxt;
        logic   hz;
        #1;
        hz = exp_hazard(cur);
        check({tag, ".hazard"}, 32'(hazard), 32'(hz));
        if (flush) nxt = bubble;
        else if (stall) nxt = cur;
        else if (hz) nxt = bubble;
        else begin
            nxt.valid  = in_valid;
            nxt.rw     = reg_write && in_valid;
            nxt.mr     = mem_read && in_valid;
            nxt.alusrc = alusrc;
            nxt.ctrl   = ctrl;
            nxt.rd     = rd_addr;
            nxt.rs     = rs_addr;
            nxt.rt     = rt_addr;
            nxt.rsd    = rs_data;
            nxt.rtd    = rt_data;
            nxt.imm    = imm;
        end
        sb.push_back(nxt);
        @(posedge clk);
        #1;
        cur = sb.pop_front();
        check_outputs(tag);
    endtask

    task automatic set_instr(input logic v, input logic [4:0] s, input logic [4:0] t,
                             input logic [4:0] d, input logic [31:0] sd, input logic [31:0] td,
                             input logic [31:0] im, input logic as, input logic [3:0] c,
                             input logic rw, input logic mr);
        in_valid = v; rs_addr = s; rt_addr = t; rd_addr = d; rs_data = sd; rt_data = td;
        imm = im; alusrc = as; ctrl = c; reg_write = rw; mem_read = mr;
    endtask

    task automatic set_wb(input logic ew, input logic [4:0] er, input logic [31:0] ed,
                          input logic mw, input logic [4:0] mrd, input logic [31:0] md);
        exmem_we = ew; exmem_rd = er; exmem_res = ed;
        memwb_we = mw; memwb_rd = mrd; memwb_data = md;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        cur = bubble;
        sb.delete();
        check_outputs(tag);
        check({tag, ".hazard"}, 32'(hazard), 32'(exp_hazard(cur)));
        @(posedge clk);
        #1;
        rst = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        bubble = '{valid: 1'b0, rw: 1'b0, mr: 1'b0, alusrc: 1'b0, ctrl: 4'd0, rd: 5'd0,
                   rs: 5'd0, rt: 5'd0, rsd: 32'd0, rtd: 32'd0, imm: 32'd0};
        cur = bubble;
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        set_instr(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2;
        do_reset("reset0");

        // Plain capture: SUBU with register operands
        set_instr(1'b1, 5'd5, 5'd6, 5'd7, 32'd10, 32'd3, 32'd0, 1'b0, 4'd5, 1'b1, 1'b0);
        step("load");

        // Forwarding priority, then fall back as writers drop out
        in_valid = 1'b0;
        stall = 1'b1;
        set_wb(1'b1, 5'd5, 32'h77, 1'b1, 5'd5, 32'h11);
        step("fwd_both");
        exmem_rd = 5'd0;
        step("fwd_memwb");
        memwb_we = 1'b0;
        step("fwd_none");
        stall = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Load-use: lw r8, then consumer of r8, then re-presented consumer
        set_instr(1'b1, 5'd1, 5'd2, 5'd8, 32'h100, 32'h0, 32'h4, 1'b1, 4'd4, 1'b1, 1'b1);
        step("lw");
        set_instr(1'b1, 5'd8, 5'd3, 5'd9, 32'h55, 32'h66, 32'h0, 1'b0, 4'd1, 1'b1, 1'b0);
        step("lu_bubble");
        step("lu_reissue");

        // Stall holds across changing inputs; flush beats stall
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(1'b1, 5'(i + 10), 5'(i + 11), 5'(i + 12), $urandom, $urandom, $urandom,
                      1'b0, 4'(i), 1'b1, 1'b0);
            step("stall");
        end
        flush = 1'b1;
        step("flush_stall");
        flush = 1'b0;
        stall = 1'b0;

        // Immediate source with rt forwarded to store data
        set_instr(1'b1, 5'd4, 5'd9, 5'd10, 32'h1, 32'h2, 32'hFFFF_FFF0, 1'b1, 4'd4, 1'b0, 1'b0);
        step("imm");
        in_valid = 1'b0;
        stall = 1'b1;
        set_wb(1'b1, 5'd9, 32'hCAFE_0001, 1'b0, 5'd0, 32'd0);
        step("imm_store");

        // Asynchronous reset in the middle of a stalled, flushed cycle
        flush = 1'b1;
        #3;
        do_reset("reset_mid");
        set_wb(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Random mix with narrow register numbers to provoke dependencies
        for (int i = 0; i < 60; i++) begin
            set_instr($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom,
                      $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 5) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
